// File: rtl/present80_core.sv
// present80_core: iterative PRESENT-80 encryption, one round per clock.
// The core runs free. It loads plaintext and key, performs 31 rounds, and then
// publishes the ciphertext on the edge that also performs the next load.
// Optional macro PRESENT_DONE_EN adds a one-clock 'done' strobe that is
// aligned with every update of 'result'.
module present80_core #(
  parameter int unsigned ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:63] state,
  input  logic [0:79] keys,
  output logic [0:63] result
`ifdef PRESENT_DONE_EN
  ,
  output logic        done
`endif
);

  localparam int unsigned DW  = 64;
  localparam int unsigned KW  = 80;
  localparam int unsigned RCW = 5;

  typedef enum logic {
    PH_LOAD = 1'b0,
    PH_RUN  = 1'b1
  } phase_t;

  phase_t           r_phase;
  phase_t           w_phase_nxt;
  logic [DW-1:0]    r_data;
  logic [DW-1:0]    w_data_nxt;
  logic [KW-1:0]    r_key;
  logic [KW-1:0]    w_key_nxt;
  logic [RCW-1:0]   r_rc;
  logic [RCW-1:0]   w_rc_nxt;
  logic [DW-1:0]    r_result;
  logic [DW-1:0]    w_result_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [DW-1:0]    w_round_key;
  logic [DW-1:0]    w_round_out;

  // 4-bit PRESENT S-box
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // S-box applied to all 16 nibbles
  function automatic logic [DW-1:0] s_layer(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit permutation: bit i goes to (16*i) mod 63, and bit 63 stays fixed
  function automatic logic [DW-1:0] p_layer(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[6'((16 * i) % 63)] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Key schedule: rotate left 61, S-box the top nibble, and XOR the round counter into [19:15]
  function automatic logic [KW-1:0] key_update(input logic [KW-1:0] k,
                                               input logic [RCW-1:0] r);
    logic [KW-1:0] t;
    t         = {k[18:0], k[79:19]};
    t[79:76]  = sbox(t[79:76]);
    t[19:15]  = t[19:15] ^ r;
    return t;
  endfunction

  assign w_round_key = r_key[79:16];
  assign w_round_out = p_layer(s_layer(r_data ^ w_round_key));

  // Phase register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_phase <= PH_LOAD;
    else     r_phase <= w_phase_nxt;
  end

  // Next phase and datapath values.
  // A nonzero rc at LOAD means a round sequence has just finished. rc is 0
  // only after reset, so the first LOAD after reset does not publish a result.
  always_comb begin
    w_phase_nxt  = r_phase;
    w_data_nxt   = r_data;
    w_key_nxt    = r_key;
    w_rc_nxt     = r_rc;
    w_result_nxt = r_result;
    w_done_nxt   = 1'b0;
    case (r_phase)
      PH_LOAD: begin
        w_data_nxt  = state;
        w_key_nxt   = keys;
        w_rc_nxt    = RCW'(1);
        w_phase_nxt = PH_RUN;
        if (r_rc != '0) begin
          w_result_nxt = r_data ^ w_round_key;
          w_done_nxt   = 1'b1;
        end
      end
      PH_RUN: begin
        w_data_nxt = w_round_out;
        w_key_nxt  = key_update(r_key, r_rc);
        if (r_rc == RCW'(ROUNDS)) begin
          w_phase_nxt = PH_LOAD;
        end else begin
          w_rc_nxt = r_rc + RCW'(1);
        end
      end
      default: w_phase_nxt = PH_LOAD;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_key    <= '0;
      r_rc     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_data   <= w_data_nxt;
      r_key    <= w_key_nxt;
      r_rc     <= w_rc_nxt;
      r_result <= w_result_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign result = r_result;

`ifdef PRESENT_DONE_EN
  assign done = r_done;
`else
  logic w_done_unused;
  assign w_done_unused = r_done;
`endif

endmodule

// File: tb/tb_present80_core.sv
// Testbench for present80_core.
// Expected ciphertexts are published PRESENT-80 known-answer vectors. They are
// queued when the inputs are applied and taken from the queue on each result
// edge. Between those edges, 'result' must hold its last value.
module tb_present80_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:63] state;
  logic [0:79] keys;
  logic [0:63] result;
`ifdef PRESENT_DONE_EN
  logic        done;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cnt      = 0;
  logic [63:0] last_exp = '0;
  logic [63:0] sb_q[$];

  localparam logic [63:0] PT_0  = 64'h0000000000000000;
  localparam logic [63:0] PT_F  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [79:0] K_0   = 80'h0;
  localparam logic [79:0] K_F   = 80'hFFFFFFFFFFFFFFFFFFFF;
  localparam logic [63:0] CT_FF = 64'h3333DCD3213210D2;
  localparam logic [63:0] CT_00 = 64'h5579C1387B228445;
  localparam logic [63:0] CT_0F = 64'hE72C46C0F5945049;
  localparam logic [63:0] CT_F0 = 64'hA112FFC72F68417B;

  present80_core dut (
    .clk    (clk),
    .rst    (rst),
    .state  (state),
    .keys   (keys),
    .result (result)
`ifdef PRESENT_DONE_EN
    ,
    .done   (done)
`endif
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it if it does not match
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cnt);
    end
  endtask

  // Applies the inputs and queues the ciphertext expected from the next LOAD
  task automatic drive(input logic [63:0] pt, input logic [79:0] k, input logic [63:0] ct);
    state = pt;
    keys  = k;
    sb_q.push_back(ct);
  endtask

  // Advances one clock and checks 'result' (and 'done') after the edge
  task automatic cycle();
    logic is_out;
    @(posedge clk);
    #1;
    cnt++;
    is_out = (cnt >= 33) && (((cnt - 1) % 32) == 0);
    if (is_out) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        last_exp = sb_q.pop_front();
        check("result", result, last_exp);
      end
    end else begin
      check("hold", result, last_exp);
    end
`ifdef PRESENT_DONE_EN
    check("done", 64'(done), 64'(is_out));
`endif
  endtask

  initial begin
    rst   = 1'b1;
    state = PT_F;
    keys  = K_F;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 64'h0);
`ifdef PRESENT_DONE_EN
    check("reset_done", 64'(done), 64'h0);
`endif

    // Release reset. Edge 1 is a LOAD, and the first result appears on edge 33.
    drive(PT_F, K_F, CT_FF);
    rst = 1'b0;
    repeat (32) cycle();
    drive(PT_0, K_0, CT_00);
    repeat (32) cycle();
    drive(PT_0, K_F, CT_0F);
    repeat (32) cycle();
    drive(PT_F, K_0, CT_F0);
    repeat (32) cycle();
    drive(PT_F, K_0, CT_F0);

    // Change the inputs 10 clocks after the LOAD on edge 129. They are not used until the LOAD on edge 161.
    repeat (10) cycle();
    drive(PT_F, K_F, CT_FF);
    repeat (22) cycle();
    repeat (32) cycle();

    // Assert reset in the middle of the encryption that started at the LOAD on edge 193
    repeat (16) cycle();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", result, 64'h0);
    @(posedge clk);
    #1;
    check("rst_hold", result, 64'h0);
`ifdef PRESENT_DONE_EN
    check("rst_done", 64'(done), 64'h0);
`endif
    sb_q.delete();
    cnt      = 0;
    last_exp = '0;
    drive(PT_0, K_0, CT_00);
    rst = 1'b0;
    repeat (64) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
